// File: rtl/gdma_pkg.sv
// Shared definitions for the GDMA-to-GTP transmit framing path.
//   frame_state_e : framer FSM states (FILL/HDR/PAY/TRL)
//   SOF_BYTE_DFLT : default start-of-frame marker
//   HDR_*         : header field bit positions
//   hdr_pack()    : assembles a header word from its fields
package gdma_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_TRL  = 2'd3
  } frame_state_e;

  localparam logic [7:0] SOF_BYTE_DFLT = 8'hBC;

  localparam int unsigned HDR_SOF_MSB = 31;
  localparam int unsigned HDR_SOF_LSB = 24;
  localparam int unsigned HDR_SEQ_MSB = 23;
  localparam int unsigned HDR_SEQ_LSB = 16;
  localparam int unsigned HDR_LEN_MSB = 15;
  localparam int unsigned HDR_LEN_LSB = 0;

  // Header word: marker, sequence number, payload length.
  function automatic logic [DATA_W-1:0] hdr_pack(input logic [7:0]  sof,
                                                 input logic [7:0]  seq,
                                                 input logic [15:0] len);
    logic [DATA_W-1:0] h;
    h = '0;
    h[HDR_SOF_MSB:HDR_SOF_LSB] = sof;
    h[HDR_SEQ_MSB:HDR_SEQ_LSB] = seq;
    h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    return h;
  endfunction

endpackage

// File: rtl/gdma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO holding one frame's payload.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push, din  : write strobe and data (ignored when full)
//   pop        : read strobe (ignored when empty)
//   dout       : current head word, valid whenever !empty
//   full/empty : occupancy flags
//   level      : number of stored words
module gdma_sync_fifo
  import gdma_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_push;
  logic              w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array; no reset needed, occupancy tracked by pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW + 1)'(1);
        2'b01:   r_level <= r_level - (AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_level == (AW + 1)'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule

// File: rtl/gtp_tx_framer.sv
// Packs the gdma2gtp payload stream into GTP TX frames:
// header {SOF, seq, len}, len payload words, XOR-checksum trailer.
//   gdma_clk, gdma_rst      : clock, async active-low reset
//   enable, flush           : input gate, close-partial-frame pulse
//   s_tvalid/s_tready/s_tdata : payload input stream
//   m_tvalid/m_tready/m_tdata/m_tlast : framed output stream
//   frame_cnt               : frames fully transmitted (wraps)
//   busy                    : anything other than FILL with empty buffer
module gtp_tx_framer
  import gdma_pkg::*;
#(
  parameter int unsigned MAX_WORDS    = 64,
  parameter int unsigned IDLE_TIMEOUT = 256,
  parameter logic [7:0]  SOF_BYTE     = SOF_BYTE_DFLT
) (
  input  logic              gdma_clk,
  input  logic              gdma_rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [31:0]       frame_cnt,
  output logic              busy
);

  localparam int unsigned CW = $clog2(MAX_WORDS) + 1;
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  frame_state_e      r_state;
  frame_state_e      w_state_nxt;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic [DATA_W-1:0] r_csum;
  logic [IW-1:0]     r_idle;
  logic [7:0]        r_seq;
  logic [31:0]       r_frame_cnt;
  logic              r_rdy_en;
  logic              w_accept;
  logic              w_timeout;
  logic              w_close;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_level;
  logic [DATA_W-1:0] w_fifo_dout;

  gdma_sync_fifo #(
    .DEPTH (MAX_WORDS)
  ) u_fifo (
    .clk   (gdma_clk),
    .rst_n (gdma_rst),
    .push  (w_accept),
    .pop   (w_pop),
    .din   (s_tdata),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // Timeout fires on the last idle cycle; s_tready is already low then.
  assign w_timeout   = (r_count != '0) && (r_idle == IW'(IDLE_TIMEOUT - 1));
  assign w_accept    = s_tvalid && s_tready;
  assign w_count_nxt = r_count + CW'(w_accept);
  // A beat accepted alongside flush belongs to the frame being closed.
  assign w_close     = (w_count_nxt == CW'(MAX_WORDS)) ||
                       (flush && (w_count_nxt != '0)) || w_timeout;
  assign w_pop       = (r_state == ST_PAY) && m_tready;
  assign frame_cnt   = r_frame_cnt;

  // State register.
  always_ff @(posedge gdma_clk or negedge gdma_rst) begin
    if (!gdma_rst) r_state <= ST_FILL;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_close)  w_state_nxt = ST_HDR;
      ST_HDR:  if (m_tready) w_state_nxt = ST_PAY;
      ST_PAY:  if (m_tready && (w_level == CW'(1))) w_state_nxt = ST_TRL;
      ST_TRL:  if (m_tready) w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // Output decode; m_tdata/m_tlast come from held registers or the FIFO head.
  always_comb begin
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    busy     = 1'b1;
    case (r_state)
      ST_FILL: begin
        s_tready = r_rdy_en && enable && !w_full && !w_timeout;
        busy     = !w_empty;
      end
      ST_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_pack(SOF_BYTE, r_seq, 16'(r_count));
      end
      ST_PAY: begin
        m_tvalid = 1'b1;
        m_tdata  = w_fifo_dout;
      end
      ST_TRL: begin
        m_tvalid = 1'b1;
        m_tdata  = r_csum;
        m_tlast  = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Frame bookkeeping: count, checksum, idle timer, sequence, frame counter.
  always_ff @(posedge gdma_clk or negedge gdma_rst) begin
    if (!gdma_rst) begin
      r_count     <= '0;
      r_csum      <= '0;
      r_idle      <= '0;
      r_seq       <= '0;
      r_frame_cnt <= '0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (r_state == ST_FILL) begin
        if (w_accept) begin
          r_count <= w_count_nxt;
          r_csum  <= r_csum ^ s_tdata;
          r_idle  <= '0;
        end else if (r_count != '0) begin
          r_idle <= r_idle + IW'(1);
        end
      end else if ((r_state == ST_TRL) && m_tready) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
        r_seq       <= r_seq + 8'd1;
        r_count     <= '0;
        r_csum      <= '0;
        r_idle      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gtp_tx_framer.sv
// Randomized bench for gtp_tx_framer: each frame's expected beats are built
// from the words pushed (header, payload, XOR trailer) and compared in order.
module tb_gtp_tx_framer;

  localparam int unsigned MAXW = 64;
  localparam int unsigned IDLE = 256;

  localparam int K_FULL       = 0;
  localparam int K_FLUSH      = 1;
  localparam int K_FLUSH_BEAT = 2;
  localparam int K_TIMEOUT    = 3;

  logic        gdma_clk = 1'b0;
  logic        gdma_rst = 1'b0;
  logic        enable   = 1'b1;
  logic        flush    = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata  = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [31:0] frame_cnt;
  logic        busy;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] stim_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int unsigned mdl_frames = 0;
  logic [7:0]  mdl_seq    = '0;

  always #5 gdma_clk = ~gdma_clk;

  gtp_tx_framer #(
    .MAX_WORDS    (MAXW),
    .IDLE_TIMEOUT (IDLE),
    .SOF_BYTE     (8'hBC)
  ) dut (
    .gdma_clk  (gdma_clk),
    .gdma_rst  (gdma_rst),
    .enable    (enable),
    .flush     (flush),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gdma_clk);
    #1;
  endtask

  // Expected beats {tlast, data} for the words currently in stim_q.
  task automatic build_exp();
    logic [31:0] x;
    x = '0;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'hBC, mdl_seq, 16'(stim_q.size())});
    foreach (stim_q[k]) begin
      exp_q.push_back({1'b0, stim_q[k]});
      x = x ^ stim_q[k];
    end
    exp_q.push_back({1'b1, x});
  endtask

  task automatic push_range(input int lo, input int hi, input bit flush_last);
    bit taken;
    int g;
    for (int k = lo; k < hi; k++) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(2, 0)) step();
      s_tvalid = 1'b1;
      s_tdata  = stim_q[k];
      flush    = flush_last && (k == hi - 1);
      taken = 1'b0;
      g = 0;
      while (!taken && g < 50) begin
        #1;
        taken = s_tready;
        step();
        g++;
      end
      s_tvalid = 1'b0;
      flush    = 1'b0;
      check("push_accept", 64'(taken), 64'd1);
    end
  endtask

  task automatic finish_frame(input int kind, input int mode);
    int          edges;
    int          cyc;
    bit          done;
    bit          prev_stall;
    logic [32:0] prev;
    if (kind == K_FLUSH) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    m_tready = 1'b0;
    edges = 0;
    while (!m_tvalid && edges < int'(IDLE) + 20) begin
      step();
      edges++;
    end
    check("close_latency", 64'(edges), 64'((kind == K_TIMEOUT) ? IDLE : 0));
    check("busy_frame", 64'(busy), 64'd1);
    got_q.delete();
    cyc = 0;
    done = 1'b0;
    prev_stall = 1'b0;
    prev = '0;
    while (!done && cyc < 4 * int'(MAXW) + 50) begin
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_tready = 1'($urandom_range(1, 0));
      endcase
      #1;
      if (prev_stall) check("stall_hold", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, prev}));
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tdata});
        done = m_tlast;
      end
      prev_stall = m_tvalid && !m_tready;
      prev = {m_tlast, m_tdata};
      step();
      cyc++;
    end
    m_tready = 1'b0;
    if (mode == 0) check("no_bubble", 64'(cyc), 64'(exp_q.size()));
    check("frame_len", 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      check("beat", 64'(got_q[k]), 64'(exp_q[k]));
    end
    mdl_frames++;
    mdl_seq++;
    check("frame_cnt", 64'(frame_cnt), 64'(mdl_frames));
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input int kind, input int mode);
    build_exp();
    push_range(0, stim_q.size(), kind == K_FLUSH_BEAT);
    finish_frame(kind, mode);
  endtask

  initial begin
    bit seen;
    int hs;
    int g;
    int n;
    int kind;

    // Reset state
    repeat (3) step();
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge gdma_clk);
    #3 gdma_rst = 1'b1;
    step();

    // Sequence wrap over 257 one-word frames
    for (int f = 0; f < 257; f++) begin
      stim_q.delete();
      stim_q.push_back($urandom);
      run_frame((f % 2) ? K_FLUSH : K_FLUSH_BEAT, 0);
    end
    check("wrap_frame_cnt", 64'(frame_cnt), 64'd257);

    // Full frame 1..64
    stim_q.delete();
    for (int k = 1; k <= int'(MAXW); k++) stim_q.push_back(32'(k));
    run_frame(K_FULL, 0);

    // Idle timeout with 0xA, 0xB, 0xC
    stim_q.delete();
    stim_q.push_back(32'hA);
    stim_q.push_back(32'hB);
    stim_q.push_back(32'hC);
    run_frame(K_TIMEOUT, 2);

    // Flush after 5 words with 1,0,0,1 backpressure
    stim_q.delete();
    for (int k = 1; k <= 5; k++) stim_q.push_back(32'(k));
    run_frame(K_FLUSH, 1);

    // Flush on an empty buffer produces nothing
    flush = 1'b1;
    step();
    flush = 1'b0;
    m_tready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      if (m_tvalid) seen = 1'b1;
      step();
    end
    m_tready = 1'b0;
    check("empty_flush_out", 64'(seen), 64'd0);
    check("empty_flush_busy", 64'(busy), 64'd0);
    check("empty_flush_cnt", 64'(frame_cnt), 64'(mdl_frames));

    // enable low mid-fill blocks input; count resumes afterwards
    stim_q.delete();
    repeat (4) stim_q.push_back($urandom);
    build_exp();
    push_range(0, 2, 1'b0);
    enable   = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = $urandom;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("disabled_ready", 64'(s_tready), 64'd0);
      step();
    end
    s_tvalid = 1'b0;
    enable   = 1'b1;
    push_range(2, 4, 1'b1);
    finish_frame(K_FLUSH_BEAT, 2);

    // enable low does not stop the idle timeout
    stim_q.delete();
    repeat (2) stim_q.push_back($urandom);
    build_exp();
    push_range(0, 2, 1'b0);
    enable = 1'b0;
    finish_frame(K_TIMEOUT, 0);
    enable = 1'b1;

    // Random frames
    repeat (6) begin
      n = $urandom_range(MAXW, 1);
      kind = (n == int'(MAXW)) ? K_FULL : int'($urandom_range(3, 1));
      stim_q.delete();
      repeat (n) stim_q.push_back($urandom);
      run_frame(kind, int'($urandom_range(2, 0)));
    end

    // Reset during payload aborts the frame
    stim_q.delete();
    for (int k = 1; k <= int'(MAXW); k++) stim_q.push_back(32'(k));
    push_range(0, MAXW, 1'b0);
    m_tready = 1'b1;
    hs = 0;
    g = 0;
    while (hs < 11 && g < 200) begin
      #1;
      if (m_tvalid && m_tready) hs++;
      step();
      g++;
    end
    check("pay_active", 64'(m_tvalid), 64'd1);
    gdma_rst = 1'b0;
    #1;
    check("abort_m_tvalid", 64'(m_tvalid), 64'd0);
    check("abort_m_tlast", 64'(m_tlast), 64'd0);
    check("abort_s_tready", 64'(s_tready), 64'd0);
    check("abort_frame_cnt", 64'(frame_cnt), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    m_tready = 1'b0;
    step();
    #2 gdma_rst = 1'b1;
    mdl_frames = 0;
    mdl_seq = '0;
    step();
    stim_q.delete();
    stim_q.push_back($urandom);
    run_frame(K_FLUSH, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gtp_tx_framer.md
Name: gtp_tx_framer

Overview:
- Sits directly downstream of the north GDMA read path and consumes its 32-bit gdma2gtp stream.
- Packs payload words into framed packets for the GTP transmit link: one header word, N payload words, one XOR-checksum trailer.
- Needs buffering because the header carries the payload length, which is only known once the frame is closed.
- Frames close on reaching the maximum size, on an idle timeout, or on an explicit flush.

Parameters:
- MAX_WORDS, 64, maximum payload words per frame (power of two, 2..1024).
- IDLE_TIMEOUT, 256, cycles with no accepted input before a partial frame is closed (>=1).
- SOF_BYTE, 8'hBC, start-of-frame marker placed in header bits [31:24].

Ports:
- gdma_clk  in  1  block clock.
- gdma_rst  in  1  reset: asynchronous assert, active-low; synchronous deassert is provided externally.
- enable  in  1  when low, no new input is accepted; a frame already being sent completes.
- flush  in  1  single-cycle pulse: close the current partial frame now.
- s_tvalid  in  1  payload valid, driven by the GDMA read-data path.
- s_tready  out  1  payload ready.
- s_tdata  in  32  payload word.
- m_tvalid  out  1  framed word valid, toward the GTP TX.
- m_tready  in  1  GTP TX ready.
- m_tdata  out  32  framed word.
- m_tlast  out  1  high on the trailer word.
- frame_cnt  out  32  frames fully transmitted; wraps.
- busy  out  1  high in any state other than FILL with an empty buffer.

Behaviour:
- Reset (gdma_rst=0), all outputs and state:
  - s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, frame_cnt=0, busy=0.
  - seq=0, word count=0, checksum=0, idle counter=0, FIFO empty, state=FILL.
- Reset asserted mid-frame aborts the frame with no trailer; the first frame after reset uses seq=0.
- FSM states: FILL, HDR, PAY, TRL.
- FILL:
  - s_tready = enable && (count < MAX_WORDS).
  - On each s_tvalid&&s_tready: push word to FIFO, count++, csum ^= s_tdata, idle counter cleared.
  - Idle counter increments on each cycle with count>0 and no accepted word.
  - Go to HDR when count==MAX_WORDS, or idle counter reaches IDLE_TIMEOUT-1 with count>0, or flush=1 with count>0.
  - flush with count==0 is ignored.
  - If flush and a valid beat arrive in the same cycle, the beat is accepted and included in the frame being closed.
  - s_tready drops combinationally in the cycle the close decision is made, so no beat is accepted on the transition.
- HDR:
  - m_tvalid=1, m_tdata={SOF_BYTE, seq[7:0], count[15:0]}, m_tlast=0; hold until m_tready, then go to PAY.
- PAY:
  - m_tdata = FIFO head, m_tvalid=1.
  - Pop on m_tvalid&&m_tready; after popping the count-th word, go to TRL.
  - No bubbles when m_tready is held high.
- TRL:
  - m_tvalid=1, m_tdata=csum, m_tlast=1.
  - On handshake: frame_cnt++, seq++ (8-bit, 255 wraps to 0), count/csum/idle cleared, back to FILL.
  - s_tready may be asserted in the cycle after the trailer handshake.
- s_tready=0 in HDR, PAY and TRL.
- Output rules:
  - m_tdata/m_tlast stay stable while m_tvalid=1 and m_tready=0 (AXI-stream rule).
  - m_tvalid never deasserts without a handshake once raised.
- Latency: with m_tready=1 and a full frame, the header is on m_tdata the cycle after the MAX_WORDS-th input beat. A frame occupies MAX_WORDS+2 output beats.
- enable deasserted in FILL with count>0: the idle timeout still runs and closes the frame.
- Widths:
  - count is clog2(MAX_WORDS)+1 bits, zero-extended into the 16-bit header field.
  - Checksum is a 32-bit XOR, initial value 0.

Decomposition:
- Shared package gdma_pkg holds:
  - frame state enum (FILL/HDR/PAY/TRL);
  - SOF_BYTE default 8'hBC;
  - header field positions (SOF [31:24], SEQ [23:16], LEN [15:0]).
- One sub-module, gdma_sync_fifo:
  - single-clock FIFO, 32 bits wide, depth MAX_WORDS;
  - ports: push, pop, din, dout, full, empty, level;
  - first-word-fall-through so the head is valid in PAY without an extra cycle.
- FSM, counters and checksum stay in gtp_tx_framer.

Test Plan:
- Full frame: push 64 words 0x1..0x40, m_tready=1 -> header 0xBC000040, 64 payload words in order, trailer 0x00000040 (XOR of 1..64) with m_tlast=1, frame_cnt=1.
- Timeout: push 3 words 0xA, 0xB, 0xC, then idle 256 cycles -> header 0xBC000003 sent on the timeout; trailer 0x0000000D.
- Flush, backpressure and boundaries:
  - 5 words then a flush pulse; m_tready toggles 1,0,0,1 every cycle -> header 0xBC000005 and trailer 0x00000001 (XOR of 1..5), m_tdata stable during stalls, no beat lost or duplicated.
  - flush with an empty buffer -> no output.
- Sequence wrap: send 257 one-word frames via flush -> the 256th header has seq 0xFF, the 257th has seq 0x00; frame_cnt=257.
- Reset mid-PAY: assert gdma_rst=0 after 10 payload beats -> m_tvalid=0 immediately (asynchronous). After release, a 1-word frame carries seq 0x00 and frame_cnt counts from 0.
- enable=0 in FILL: s_tready=0 and no beats accepted. Re-enabling resumes with count continuing from its prior value.
